// File: rtl/fpu_pkg.sv
// Shared single-precision FPU constants and the packed float layout.
// Pure declarations: no latency, no flow control.
package fpu_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] POS_ZERO = 32'h0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } sp_t;
endpackage

// File: rtl/lzc32.sv
// Leading-zero counter for a 32-bit word; cnt is don't-care when all_zero.
// Purely combinational, no flow control.
module lzc32 (
  input  logic [31:0] x,
  output logic [4:0]  cnt,
  output logic        all_zero
);
  logic hit;

  always_comb begin
    cnt = 5'd0;
    hit = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!hit) begin
        if (x[i]) hit = 1'b1;
        else      cnt = cnt + 5'd1;
      end
    end
  end

  assign all_zero = ~|x;
endmodule

// File: rtl/fcvt_s_w_pipe.sv
// int32 -> IEEE single (RNE) with NX flag; FCVT_UNSIGNED_EN adds in_unsigned (fcvt.s.wu).
// Latency 2 cycles, 1 result/cycle; both stages stall together while out_valid & !out_ready.
module fcvt_s_w_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
`ifdef FCVT_UNSIGNED_EN
  input  logic        in_unsigned,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic        out_inexact
);
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + 31);

  logic        adv;
  logic        x_sign;
  logic [31:0] x_mag;
  logic [4:0]  x_lzc;
  logic        x_zero;

  logic        s1_valid;
  logic        s1_sign;
  logic [31:0] s1_mag;
  logic [4:0]  s1_lzc;
  logic        s1_zero;

  logic [30:0] norm;
  logic        guard;
  logic        sticky;
  logic        rup;
  logic [23:0] frac_sum;
  sp_t         res;
  logic [31:0] y_nxt;
  logic        nx_nxt;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
`ifdef FCVT_UNSIGNED_EN
    x_sign = in_x[31] & ~in_unsigned;
`else
    x_sign = in_x[31];
`endif
    x_mag = x_sign ? (~in_x + 32'd1) : in_x;
  end

  lzc32 u_lzc (
    .x        (x_mag),
    .cnt      (x_lzc),
    .all_zero (x_zero)
  );

  // The implicit leading one is shifted out of norm; only fraction bits remain.
  always_comb begin
    norm     = 31'(s1_mag << s1_lzc);
    guard    = norm[7];
    sticky   = |norm[6:0];
    rup      = guard & (sticky | norm[8]);
    frac_sum = {1'b0, norm[30:8]} + {23'd0, rup};
    res.sign = s1_sign;
    res.exp  = EXP_TOP - {3'd0, s1_lzc} + {7'd0, frac_sum[23]};
    res.frac = frac_sum[22:0];
    y_nxt    = s1_zero ? POS_ZERO : res;
    nx_nxt   = ~s1_zero & (guard | sticky);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_mag      <= 32'd0;
      s1_lzc      <= 5'd0;
      s1_zero     <= 1'b0;
      out_valid   <= 1'b0;
      out_y       <= 32'd0;
      out_inexact <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_sign <= x_sign;
        s1_mag  <= x_mag;
        s1_lzc  <= x_lzc;
        s1_zero <= x_zero;
      end
      if (s1_valid) begin
        out_y       <= y_nxt;
        out_inexact <= nx_nxt;
      end
    end
  end
endmodule
